// File: rtl/vga_fb_scanout.sv
// vga_fb_scanout: VGA scan-out engine.
//   Counter stage generates h/v timing and issues one framebuffer read per
//   memory word; returning words land in a 2-entry FIFO; the output stage runs
//   LAG = RD_LAT+1 pixel ticks behind, unpacks/upscales the word and drives
//   registered RGB, sync and blank pads.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   pix_en           pixel-clock enable (all timing advances only when high)
//   fb_base          word address of source pixel (0,0), taken once per frame
//   mem_addr/mem_rd  framebuffer read address and one-clk read strobe
//   mem_rdata        read data, valid RD_LAT clks after mem_rd
//   rgb              pixel colour, 0 while blank
//   h_sync/v_sync    sync pads, asserted level = SYNC_POL
//   blank            high outside the active area
//   frame_start      one-clk pulse when the output stage shows pixel (0,0)
module vga_fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int MEM_AW     = 14,
  parameter int MEM_DW     = 16,
  parameter int BPP        = 8,
  parameter int SCALE_LOG2 = 2,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [MEM_AW-1:0] fb_base,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [MEM_DW-1:0] mem_rdata,
  output logic [BPP-1:0]    rgb,
  output logic              h_sync,
  output logic              v_sync,
  output logic              blank,
  output logic              frame_start
);
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int PPW      = MEM_DW / BPP;
  localparam int PPW_LOG2 = $clog2(PPW);
  localparam int WSHIFT   = PPW_LOG2 + SCALE_LOG2;
  localparam int SPAN     = 1 << WSHIFT;           // screen pixels per word
  localparam int SMASK    = (1 << SCALE_LOG2) - 1;
  localparam int SRC_W    = H_ACTIVE >> SCALE_LOG2;
  localparam int WPL      = SRC_W / PPW;
  localparam int LAG      = RD_LAT + 1;
  localparam int KW       = (PPW_LOG2 > 0) ? PPW_LOG2 : 1;

  // ---------------- counter stage ----------------
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [MEM_AW-1:0] base_q, line_addr_q, mem_addr_q;
  logic              mem_rd_q;
  logic              h_wrap, v_wrap, c_act, c_hs, c_vs, c_sof, c_last, fetch, line_step;
  logic [KW-1:0]     c_k;

  assign h_wrap    = int'(h_cnt_q) == H_TOTAL - 1;
  assign v_wrap    = int'(v_cnt_q) == V_TOTAL - 1;
  assign c_act     = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
  assign c_hs      = (int'(h_cnt_q) >= H_ACTIVE + H_FP) && (int'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
  assign c_vs      = (int'(v_cnt_q) >= V_ACTIVE + V_FP) && (int'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);
  assign c_sof     = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign fetch     = c_act && ((int'(h_cnt_q) & (SPAN - 1)) == 0);
  assign c_last    = (int'(h_cnt_q) & (SPAN - 1)) == SPAN - 1;
  assign c_k       = KW'((int'(h_cnt_q) >> SCALE_LOG2) & (PPW - 1));
  // Step to the next source line after the last replica of the current one.
  assign line_step = c_act && (int'(h_cnt_q) == H_ACTIVE - 1) && ((int'(v_cnt_q) & SMASK) == SMASK);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      base_q      <= fb_base;
      line_addr_q <= fb_base;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      mem_rd_q <= pix_en && fetch;
      if (pix_en && fetch)
        mem_addr_q <= line_addr_q + MEM_AW'(int'(h_cnt_q) >> WSHIFT);
      if (pix_en) begin
        // Latch the next frame's base on entering the first blank line so a
        // mid-frame fb_base change never tears the current frame.
        if (h_wrap && (int'(v_cnt_q) == V_ACTIVE - 1)) base_q <= fb_base;
        if (h_wrap && v_wrap)  line_addr_q <= base_q;
        else if (line_step)    line_addr_q <= line_addr_q + MEM_AW'(WPL);
      end
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

  // ---------------- delay line to the output stage ----------------
  logic [LAG-1:0]         act_p, hs_p, vs_p, sof_p, last_p;
  logic [LAG-1:0][KW-1:0] k_p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_p <= '0; hs_p <= '0; vs_p <= '0; sof_p <= '0; last_p <= '0; k_p <= '0;
    end else if (pix_en) begin
      act_p[0] <= c_act; hs_p[0] <= c_hs; vs_p[0] <= c_vs;
      sof_p[0] <= c_sof; last_p[0] <= c_last; k_p[0] <= c_k;
      for (int i = 1; i < LAG; i++) begin
        act_p[i] <= act_p[i-1]; hs_p[i] <= hs_p[i-1]; vs_p[i] <= vs_p[i-1];
        sof_p[i] <= sof_p[i-1]; last_p[i] <= last_p[i-1]; k_p[i] <= k_p[i-1];
      end
    end
  end

  // ---------------- return path and word FIFO ----------------
  // Capture is clk-timed so data is never lost during pix_en gaps.
  logic [RD_LAT-1:0]          vld_pipe_q;
  logic [1:0][MEM_DW-1:0]     fifo_q;
  logic                       wr_ptr_q, rd_ptr_q;
  logic [1:0]                 cnt_q;
  logic                       push, pop, fifo_empty, have, do_pop, pop_store, wr_en;
  logic [PPW-1:0][BPP-1:0]    head_pix;

  assign push       = vld_pipe_q[RD_LAT-1];
  assign pop        = pix_en && act_p[LAG-1] && last_p[LAG-1];
  assign fifo_empty = cnt_q == 2'd0;
  // With pix_en every clk a word arrives on the same edge its first pixel is
  // shown, so an empty FIFO forwards mem_rdata straight through.
  assign have       = !fifo_empty || push;
  assign head_pix   = fifo_empty ? mem_rdata : fifo_q[rd_ptr_q];
  assign do_pop     = pop && have;
  assign pop_store  = do_pop && !fifo_empty;
  assign wr_en      = push && !(do_pop && fifo_empty) && ((cnt_q != 2'd2) || pop_store);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      fifo_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      vld_pipe_q[0] <= mem_rd_q;
      for (int i = 1; i < RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      if (pop_store) rd_ptr_q <= ~rd_ptr_q;
      if (wr_en) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      cnt_q <= cnt_q + 2'(wr_en) - 2'(pop_store);
    end
  end

  a_fifo_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n) !(pop && !have));
  a_fifo_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                        !(push && (cnt_q == 2'd2) && !pop_store));

  // ---------------- output registers ----------------
  logic [BPP-1:0] rgb_q;
  logic           blank_q, hs_q, vs_q, fs_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      blank_q <= 1'b1;
      hs_q    <= !SYNC_POL;
      vs_q    <= !SYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      fs_q <= pix_en && sof_p[LAG-1];
      if (pix_en) begin
        rgb_q   <= (act_p[LAG-1] && have) ? head_pix[k_p[LAG-1]] : '0;
        blank_q <= !act_p[LAG-1];
        hs_q    <= hs_p[LAG-1] ? SYNC_POL : !SYNC_POL;
        vs_q    <= vs_p[LAG-1] ? SYNC_POL : !SYNC_POL;
      end
    end
  end

  assign rgb         = rgb_q;
  assign blank       = blank_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign frame_start = fs_q;
endmodule
